// File: rtl/register_load_debouncer.sv
// Synchronise and debounce the load pushbutton, capture the switch word on
// each accepted press and emit a stretched load strobe for a divided-clock register.
module register_load_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  output logic [WIDTH-1:0] data_out,
  output logic             load_out,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW =
    (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] STR_INIT =
    SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    WAIT_RELEASE
  } state_e;

  logic             btn_meta_q;
  logic             btn_sync_q;
  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  logic          btn_db_q;
  logic          btn_db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // any return to the accepted level restarts the count
  always_comb begin
    btn_db_d = btn_db_q;
    cnt_d    = cnt_q;
    if (btn_sync_q == btn_db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      btn_db_d = btn_sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      cnt_q    <= cnt_d;
    end
  end

  // registered copy of the debounced level seen by the FSM
  logic btn_lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_lvl_q <= 1'b0;
    end else begin
      btn_lvl_q <= btn_db_q;
    end
  end

  state_e           state_q;
  logic [SW-1:0]    str_q;
  logic [WIDTH-1:0] data_q;
  logic             load_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      str_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (btn_lvl_q) begin
            state_q <= PULSE;
            data_q  <= sw_sync_q;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            str_q   <= STR_INIT;
          end
        end
        PULSE: begin
          if (str_q == '0) begin
            load_q  <= 1'b0;
            state_q <= WAIT_RELEASE;
          end else begin
            str_q <= str_q - 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!btn_lvl_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_q;
  assign load_out = load_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_register_load_debouncer.sv
// Bench for register_load_debouncer: directed scenarios plus random
// button/switch traffic against a cycle-level behavioural model.
module tb_register_load_debouncer;

  localparam int DB  = 16;
  localparam int STR = 8;

  logic       clk;
  logic       reset;
  logic [3:0] sw_raw;
  logic       btn_raw;
  logic [3:0] data_out;
  logic       load_out;
  logic       busy;

  register_load_debouncer #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(DB),
    .STRETCH_CYCLES(STR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .btn_raw(btn_raw),
    .data_out(data_out),
    .load_out(load_out),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // behavioural model: sample pipeline, run-length debounce, service flag
  bit       m_s1, m_sync, m_db, m_lvl, m_serving;
  int       m_run, m_left;
  bit [3:0] m_sw1, m_sw2, m_data;

  task automatic model_step();
    bit new_db;
    if (!reset) begin
      m_s1 = 0; m_sync = 0; m_db = 0; m_lvl = 0;
      m_serving = 0; m_run = 0; m_left = 0;
      m_sw1 = 0; m_sw2 = 0; m_data = 0;
    end else begin
      if (!m_serving) begin
        if (m_lvl) begin
          m_serving = 1;
          m_left = STR;
          m_data = m_sw2;
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (!m_lvl) begin
        m_serving = 0;
      end
      m_lvl = m_db;
      new_db = m_db;
      if (m_sync != m_db) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        new_db = m_sync;
        m_run = 0;
      end
      m_db = new_db;
      m_sync = m_s1;
      m_s1 = btn_raw;
      m_sw2 = m_sw1;
      m_sw1 = sw_raw;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  int  edge_no = 0;
  int  rise_edge = -1, fall_edge = -1, busy_fall = -1;
  int  n_rise = 0;
  bit  load_prev = 0, busy_prev = 0;

  initial begin
    forever begin
      @(posedge clk);
      edge_no++;
      #1;
      if (load_out && !load_prev) begin
        rise_edge = edge_no;
        n_rise++;
      end
      if (!load_out && load_prev) fall_edge = edge_no;
      if (!busy && busy_prev) busy_fall = edge_no;
      load_prev = load_out;
      busy_prev = busy;
    end
  end

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("load", {31'd0, load_out}, {31'd0, m_left > 0});
      chk("busy", {31'd0, busy}, {31'd0, m_serving});
      chk("data", {28'd0, data_out}, {28'd0, m_data});
    end
  endtask

  int e0, r0, n0;

  initial begin
    reset = 1'b0;
    btn_raw = 1'b0;
    sw_raw = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_load", {31'd0, load_out}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {28'd0, data_out}, 0);
    reset = 1'b1;
    run_cycles(5);

    // clean press
    n0 = n_rise;
    sw_raw = 4'hA;
    btn_raw = 1'b1;
    e0 = edge_no + 1;
    run_cycles(40);
    chk("t1_lat", rise_edge - e0, DB + 3);
    chk("t1_len", fall_edge - rise_edge, STR);
    chk("t1_cnt", n_rise - n0, 1);
    chk("t1_data", {28'd0, data_out}, 4'hA);
    btn_raw = 1'b0;
    run_cycles(40);
    chk("t1_idle", {31'd0, busy}, 0);

    // bouncing press
    n0 = n_rise;
    for (int k = 0; k < 8; k++) begin
      btn_raw = (k % 2 == 0);
      run_cycles(5);
    end
    chk("t2_nobounce", n_rise - n0, 0);
    btn_raw = 1'b1;
    e0 = edge_no + 1;
    run_cycles(40);
    chk("t2_lat", rise_edge - e0, DB + 3);
    chk("t2_cnt", n_rise - n0, 1);
    chk("t2_len", fall_edge - rise_edge, STR);
    btn_raw = 1'b0;
    run_cycles(40);

    // held press, switch changes mid-strobe
    n0 = n_rise;
    sw_raw = 4'h3;
    btn_raw = 1'b1;
    run_cycles(25);
    sw_raw = 4'hC;
    run_cycles(175);
    chk("t3_data", {28'd0, data_out}, 4'h3);
    chk("t3_busy", {31'd0, busy}, 1);
    chk("t3_cnt", n_rise - n0, 1);
    btn_raw = 1'b0;
    r0 = edge_no + 1;
    run_cycles(30);
    chk("t3_rel", busy_fall - r0, DB + 3);

    // two presses
    n0 = n_rise;
    sw_raw = 4'h5;
    btn_raw = 1'b1;
    run_cycles(40);
    chk("t4_data1", {28'd0, data_out}, 4'h5);
    btn_raw = 1'b0;
    run_cycles(30);
    chk("t4_gap", {31'd0, busy}, 0);
    sw_raw = 4'hF;
    btn_raw = 1'b1;
    run_cycles(40);
    chk("t4_data2", {28'd0, data_out}, 4'hF);
    chk("t4_cnt", n_rise - n0, 2);
    btn_raw = 1'b0;
    run_cycles(40);

    // async reset on the 4th strobe cycle
    sw_raw = 4'h9;
    btn_raw = 1'b1;
    run_cycles(23);
    chk("t5_pre", {31'd0, load_out}, 1);
    reset = 1'b0;
    #1;
    chk("t5_load", {31'd0, load_out}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_data", {28'd0, data_out}, 0);
    #2;
    reset = 1'b1;
    e0 = edge_no + 1;
    run_cycles(25);
    chk("t5_lat", rise_edge - e0, DB + 3);
    btn_raw = 1'b0;
    run_cycles(40);

    // short glitch
    n0 = n_rise;
    sw_raw = 4'h7;
    btn_raw = 1'b1;
    run_cycles(10);
    btn_raw = 1'b0;
    run_cycles(30);
    chk("t6_cnt", n_rise - n0, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_data", {28'd0, data_out}, 4'h9);

    // random traffic
    for (int s = 0; s < 120; s++) begin
      btn_raw = 1'($urandom_range(0, 1));
      sw_raw = 4'($urandom);
      run_cycles($urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_load_debouncer.md
Name: register_load_debouncer

Overview:
- Front-end stage that feeds the clock-divided 4-bit load register.
- Synchronizes and debounces a raw pushbutton, and captures the synchronized 4-bit switch value on each accepted press.
- Emits a load strobe stretched long enough to be seen by a register running on a divided clock.
- Runs on the undivided board clock; its data_out/load_out drive the register's In/load.

Parameters:
- WIDTH, 4, width of switch input and captured data.
- DEBOUNCE_CYCLES, 16, consecutive clk cycles the synchronized button must differ from its accepted level before the new level is accepted (>=2).
- STRETCH_CYCLES, 8, clk cycles load_out is held high per accepted press (>=1; set >= divider ratio).

Ports:
- clk  input  1  board clock.
- reset  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw switch levels, asynchronous to clk.
- btn_raw  input  1  raw load pushbutton, asynchronous to clk, bouncy, 1 = pressed.
- data_out  output  WIDTH  captured switch value; drives register In.
- load_out  output  1  stretched load strobe; drives register load.
- busy  output  1  high while a press is being serviced (PULSE or WAIT_RELEASE).

Behaviour:
- Reset (reset=0, async): all synchronizer flops 0, debounced level 0, debounce counter 0, state IDLE, data_out=0, load_out=0, busy=0. All outputs are registered.
- Synchronizers: two flops each on btn_raw and on every sw_raw bit, giving btn_sync and sw_sync. Switches are not debounced; their value is sampled only at capture.
- Debounce counter: width ceil(log2(DEBOUNCE_CYCLES)).
  - If btn_sync == btn_db, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, btn_db <= btn_sync and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any bounce back to the accepted level before the count completes restarts the count.
- FSM states: IDLE, PULSE, WAIT_RELEASE.
  - IDLE: when btn_db==1, go to PULSE, set data_out <= sw_sync (same edge), set load_out <= 1, and load stretch counter with STRETCH_CYCLES-1.
  - PULSE: load_out=1. Decrement the stretch counter. At 0, load_out <= 0 and go to WAIT_RELEASE.
  - WAIT_RELEASE: when btn_db==0, go to IDLE on the next edge. Otherwise stay.
  - busy is 1 in PULSE and WAIT_RELEASE, 0 in IDLE.
- Latency: btn_raw first sampled high at edge E0 and held steady means load_out rises at edge E(DEBOUNCE_CYCLES+3) (19 with defaults). It stays high exactly STRETCH_CYCLES cycles.
- data_out changes only on the IDLE->PULSE edge and holds between presses. Switch changes during PULSE or WAIT_RELEASE are ignored.
- One accepted press produces exactly one strobe. Holding the button produces no repeat strobes; a new strobe requires a debounced release then a debounced press.
- Release during PULSE: the strobe still completes its full STRETCH_CYCLES. The FSM then passes through WAIT_RELEASE, exiting on the first edge that sees btn_db==0.
- Reset asserted mid-PULSE: load_out, busy and data_out clear immediately (asynchronously). After reset deasserts, a still-held button must be re-debounced (btn_db=0) before a new strobe is produced.
- No combinational path from any input to any output.

Test Plan:
- Reset, then sw_raw=4'b1010 and btn_raw held high cleanly from edge E0 -> load_out high on edges E19..E26 (8 cycles), data_out=4'hA from E19, busy high from E19.
- Bouncing press: btn_raw toggles every 5 cycles for 40 cycles, then held high -> no strobe during bouncing. Exactly one 8-cycle strobe, 19 edges after the final stable rise.
- Held press plus switch change: sw_raw=4'h3 at press; change to 4'hC during the strobe while the button stays held 200 cycles -> single strobe, data_out stays 4'h3, busy stays 1 until 19 cycles after the debounced release.
- Two presses separated by a clean 30-cycle release, sw_raw 4'h5 then 4'hF -> two strobes; data_out 4'h5 then 4'hF; busy drops between them.
- Async reset pulse (reset=0 for 3 ns) on the 4th strobe cycle -> load_out, busy and data_out go 0 immediately. With the button still held after reset, a new strobe appears 19 edges after reset deassertion.
- Glitch shorter than DEBOUNCE_CYCLES (btn_raw high for 10 cycles, then low) -> no strobe, busy stays 0, data_out unchanged.
